// File: rtl/hazard_forward_unit_if.sv
// Decode-side bundle for the hazard/forwarding unit: decode fields, forwarding sources,
// stall inputs, and the operand-mux / pipeline-enable controls returned to the pipeline.
interface hazard_forward_unit_if #(
  parameter int XLEN          = 64,
  parameter int REGISTER_SIZE = 5,
  parameter int FWD_DEPTH     = 2,
  parameter int CNT_WIDTH     = 32
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                      dec_valid;
  logic [REGISTER_SIZE-1:0]  dec_rd;
  logic [REGISTER_SIZE-1:0]  dec_rs1;
  logic [REGISTER_SIZE-1:0]  dec_rs2;
  logic                      dec_rd_we;
  logic                      dec_uses_rs1;
  logic                      dec_uses_rs2;
  logic                      dec_is_load;
  logic                      dec_is_store;
  logic                      dec_is_fence;
  logic [XLEN-1:0]           rf_rs1_data;
  logic [XLEN-1:0]           rf_rs2_data;
  logic [FWD_DEPTH*XLEN-1:0] stage_result;
  logic                      mc_busy;
  logic                      dm_pending;

  logic [XLEN-1:0]           fwd_rs1_data;
  logic [XLEN-1:0]           fwd_rs2_data;
  logic [SEL_W-1:0]          fwd_sel_rs1;
  logic [SEL_W-1:0]          fwd_sel_rs2;
  logic                      f_to_d_enable_ff;
  logic                      d_to_e_enable_ff;
  logic                      d_to_e_bubble;
  logic [1:0]                stall_state;
  logic [CNT_WIDTH-1:0]      stall_cycles;

  modport master (
    output dec_valid, dec_rd, dec_rs1, dec_rs2, dec_rd_we, dec_uses_rs1, dec_uses_rs2,
           dec_is_load, dec_is_store, dec_is_fence, rf_rs1_data, rf_rs2_data,
           stage_result, mc_busy, dm_pending,
    input  fwd_rs1_data, fwd_rs2_data, fwd_sel_rs1, fwd_sel_rs2,
           f_to_d_enable_ff, d_to_e_enable_ff, d_to_e_bubble, stall_state, stall_cycles
  );

  modport slave (
    input  dec_valid, dec_rd, dec_rs1, dec_rs2, dec_rd_we, dec_uses_rs1, dec_uses_rs2,
           dec_is_load, dec_is_store, dec_is_fence, rf_rs1_data, rf_rs2_data,
           stage_result, mc_busy, dm_pending,
    output fwd_rs1_data, fwd_rs2_data, fwd_sel_rs1, fwd_sel_rs2,
           f_to_d_enable_ff, d_to_e_enable_ff, d_to_e_bubble, stall_state, stall_cycles
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Data-hazard, forwarding and stall controller beside decode: picks the youngest ready
// producer per source operand and stalls for load-use, FENCE drain and busy multi-cycle units.
module hazard_forward_unit #(
  parameter int XLEN          = 64,
  parameter int REGISTER_SIZE = 5,
  parameter int FWD_DEPTH     = 2,
  parameter int LOAD_LATENCY  = 1,
  parameter int CNT_WIDTH     = 32
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_unit_if.slave hz
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    LOAD_STALL  = 2'd1,
    MC_STALL    = 2'd2,
    FENCE_DRAIN = 2'd3
  } stall_state_e;

  typedef struct packed {
    logic                     valid;
    logic [REGISTER_SIZE-1:0] rd;
    logic                     rd_we;
    logic                     is_load;
    logic                     is_mem;
  } trk_entry_t;

  // Index 0 is stage 1 (execute); index FWD_DEPTH-1 is the oldest tracked stage.
  trk_entry_t trk_q [FWD_DEPTH];
  trk_entry_t dec_entry;

  stall_state_e         state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic                 rs1_hit, rs1_ready, rs2_hit, rs2_ready;
  logic [SEL_W-1:0]     rs1_sel, rs2_sel;
  logic [XLEN-1:0]      rs1_fwd, rs2_fwd;
  logic                 mem_in_flight;
  logic                 load_use, fence_wait;
  logic                 f_to_d_en, d_to_e_en, bubble, freeze, accept;

  function automatic logic entry_matches(input trk_entry_t e,
                                         input logic [REGISTER_SIZE-1:0] src,
                                         input logic uses);
    return e.valid && e.rd_we && (e.rd == src) && (src != '0) && uses;
  endfunction

  // Scan oldest to youngest so the youngest matching stage overrides older ones.
  always_comb begin
    rs1_hit   = 1'b0;
    rs1_ready = 1'b1;
    rs1_sel   = '0;
    rs1_fwd   = hz.rf_rs1_data;
    if (!rst) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (entry_matches(trk_q[k-1], hz.dec_rs1, hz.dec_uses_rs1)) begin
          rs1_hit   = 1'b1;
          rs1_ready = !trk_q[k-1].is_load || (k > LOAD_LATENCY);
          rs1_sel   = SEL_W'(k);
          rs1_fwd   = hz.stage_result[(k-1)*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    rs2_hit   = 1'b0;
    rs2_ready = 1'b1;
    rs2_sel   = '0;
    rs2_fwd   = hz.rf_rs2_data;
    if (!rst) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (entry_matches(trk_q[k-1], hz.dec_rs2, hz.dec_uses_rs2)) begin
          rs2_hit   = 1'b1;
          rs2_ready = !trk_q[k-1].is_load || (k > LOAD_LATENCY);
          rs2_sel   = SEL_W'(k);
          rs2_fwd   = hz.stage_result[(k-1)*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    mem_in_flight = hz.dm_pending;
    for (int k = 0; k < FWD_DEPTH; k++) begin
      if (trk_q[k].valid && trk_q[k].is_mem) begin
        mem_in_flight = 1'b1;
      end
    end
  end

  // A not-ready youngest producer stalls even when an older ready copy exists.
  assign load_use   = hz.dec_valid && ((rs1_hit && !rs1_ready) || (rs2_hit && !rs2_ready));
  assign fence_wait = hz.dec_valid && hz.dec_is_fence && mem_in_flight;

  // Outputs react to this cycle's conditions; the state register only records them.
  always_comb begin
    state_d   = RUN;
    f_to_d_en = 1'b1;
    d_to_e_en = 1'b1;
    bubble    = 1'b0;
    freeze    = 1'b0;
    if (!rst) begin
      if (hz.mc_busy) begin
        state_d   = MC_STALL;
        f_to_d_en = 1'b0;
        d_to_e_en = 1'b0;
        freeze    = 1'b1;
      end else if (fence_wait) begin
        state_d   = FENCE_DRAIN;
        f_to_d_en = 1'b0;
        bubble    = 1'b1;
      end else if (load_use) begin
        state_d   = LOAD_STALL;
        f_to_d_en = 1'b0;
        bubble    = 1'b1;
      end
    end
  end

  always_comb begin
    dec_entry         = '0;
    dec_entry.valid   = 1'b1;
    dec_entry.rd      = hz.dec_rd;
    dec_entry.rd_we   = hz.dec_rd_we;
    dec_entry.is_load = hz.dec_is_load;
    dec_entry.is_mem  = hz.dec_is_load || hz.dec_is_store;
  end

  assign accept = hz.dec_valid && d_to_e_en && !bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FWD_DEPTH; k++) begin
        trk_q[k] <= '0;
      end
    end else if (!freeze) begin
      trk_q[0] <= accept ? dec_entry : '0;
      for (int k = 1; k < FWD_DEPTH; k++) begin
        trk_q[k] <= trk_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!f_to_d_en && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign hz.fwd_rs1_data     = rs1_fwd;
  assign hz.fwd_rs2_data     = rs2_fwd;
  assign hz.fwd_sel_rs1      = rs1_sel;
  assign hz.fwd_sel_rs2      = rs2_sel;
  assign hz.f_to_d_enable_ff = f_to_d_en;
  assign hz.d_to_e_enable_ff = d_to_e_en;
  assign hz.d_to_e_bubble    = bubble;
  assign hz.stall_state      = state_q;
  assign hz.stall_cycles     = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: each step drives decode/pipeline inputs, queues the
// expected outputs, and compares them shortly after the inputs settle.
module tb_hazard_forward_unit;
  localparam int XLEN          = 64;
  localparam int REGISTER_SIZE = 5;
  localparam int FWD_DEPTH     = 2;
  localparam int LOAD_LATENCY  = 1;
  localparam int CNT_WIDTH     = 32;

  typedef enum {
    K_SEL1, K_SEL2, K_D1, K_D2, K_F2D, K_D2E, K_BUB, K_STATE, K_CNT
  } chk_kind_e;

  typedef struct {
    chk_kind_e   kind;
    logic [63:0] value;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst;
  exp_t  sb[$];
  int    n_checks = 0;
  int    n_fail = 0;
  string step_name = "init";

  hazard_forward_unit_if #(
    .XLEN(XLEN), .REGISTER_SIZE(REGISTER_SIZE), .FWD_DEPTH(FWD_DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) hz ();

  hazard_forward_unit #(
    .XLEN(XLEN), .REGISTER_SIZE(REGISTER_SIZE), .FWD_DEPTH(FWD_DEPTH),
    .LOAD_LATENCY(LOAD_LATENCY), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] observe(input chk_kind_e k);
    case (k)
      K_SEL1:  return 64'(hz.fwd_sel_rs1);
      K_SEL2:  return 64'(hz.fwd_sel_rs2);
      K_D1:    return hz.fwd_rs1_data;
      K_D2:    return hz.fwd_rs2_data;
      K_F2D:   return 64'(hz.f_to_d_enable_ff);
      K_D2E:   return 64'(hz.d_to_e_enable_ff);
      K_BUB:   return 64'(hz.d_to_e_bubble);
      K_STATE: return 64'(hz.stall_state);
      default: return 64'(hz.stall_cycles);
    endcase
  endfunction

  task automatic expect_out(input chk_kind_e k, input logic [63:0] v);
    exp_t e;
    e.kind  = k;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic expect_ctrl(input logic f2d, input logic d2e, input logic bub);
    expect_out(K_F2D, 64'(f2d));
    expect_out(K_D2E, 64'(d2e));
    expect_out(K_BUB, 64'(bub));
  endtask

  task automatic expect_regs(input logic [1:0] st, input logic [CNT_WIDTH-1:0] cnt);
    expect_out(K_STATE, 64'(st));
    expect_out(K_CNT, 64'(cnt));
  endtask

  task automatic apply_stimulus(input string name, input logic v,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic we, input logic u1, input logic u2,
                                input logic ld, input logic st, input logic fn);
    @(negedge clk);
    step_name       = name;
    hz.dec_valid    = v;
    hz.dec_rd       = rd;
    hz.dec_rs1      = rs1;
    hz.dec_rs2      = rs2;
    hz.dec_rd_we    = we;
    hz.dec_uses_rs1 = u1;
    hz.dec_uses_rs2 = u2;
    hz.dec_is_load  = ld;
    hz.dec_is_store = st;
    hz.dec_is_fence = fn;
  endtask

  task automatic check_output();
    exp_t        e;
    logic [63:0] obs;
    #2;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      n_checks++;
      assert (obs === e.value) else begin
        n_fail++;
        $error("[TB] FAIL %s/%s observed=0x%0h expected=0x%0h",
               step_name, e.kind.name(), obs, e.value);
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    hz.dec_valid    = 1'b0;
    hz.dec_rd       = '0;
    hz.dec_rs1      = '0;
    hz.dec_rs2      = '0;
    hz.dec_rd_we    = 1'b0;
    hz.dec_uses_rs1 = 1'b0;
    hz.dec_uses_rs2 = 1'b0;
    hz.dec_is_load  = 1'b0;
    hz.dec_is_store = 1'b0;
    hz.dec_is_fence = 1'b0;
    hz.rf_rs1_data  = 64'hAAAA_0001;
    hz.rf_rs2_data  = 64'hBBBB_0002;
    hz.stage_result = '0;
    hz.mc_busy      = 1'b1;
    hz.dm_pending   = 1'b0;

    // Reset overrides any stall request and forwarding.
    apply_stimulus("reset", 1, 6, 5, 5, 1, 1, 1, 0, 0, 0);
    expect_ctrl(1, 1, 0);
    expect_out(K_SEL1, 0);
    expect_out(K_D1, 64'hAAAA_0001);
    check_output();

    // add x5
    apply_stimulus("add_x5", 1, 5, 0, 0, 1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    hz.mc_busy = 1'b0;
    expect_regs(0, 0);
    expect_out(K_SEL1, 0);
    expect_ctrl(1, 1, 0);
    check_output();

    // sub x6,x5,x5 forwards from stage 1
    apply_stimulus("sub_fwd", 1, 6, 5, 5, 1, 1, 1, 0, 0, 0);
    hz.stage_result = {64'h0, 64'h10};
    expect_out(K_SEL1, 1);
    expect_out(K_SEL2, 1);
    expect_out(K_D1, 64'h10);
    expect_out(K_D2, 64'h10);
    expect_ctrl(1, 1, 0);
    check_output();

    // ld x7
    apply_stimulus("ld_x7", 1, 7, 0, 0, 1, 1, 0, 1, 0, 0);
    expect_out(K_SEL1, 0);
    expect_out(K_D1, 64'hAAAA_0001);
    check_output();

    // add x8,x7,x0: load-use stall, one bubble
    apply_stimulus("load_use", 1, 8, 7, 0, 1, 1, 1, 0, 0, 0);
    hz.stage_result = {64'h0, 64'h99};
    expect_ctrl(0, 1, 1);
    expect_regs(0, 0);
    check_output();

    // Same add after the stall: load now ready in stage 2
    apply_stimulus("load_fwd", 1, 8, 7, 0, 1, 1, 1, 0, 0, 0);
    hz.stage_result = {64'h77, 64'h99};
    expect_ctrl(1, 1, 0);
    expect_out(K_SEL1, 2);
    expect_out(K_D1, 64'h77);
    expect_out(K_SEL2, 0);
    expect_regs(1, 1);
    check_output();

    // addi x9,x0,1 then addi x9,x9,1 then add x10,x9,x0
    apply_stimulus("addi_a", 1, 9, 0, 0, 1, 1, 0, 0, 0, 0);
    expect_regs(0, 1);
    expect_ctrl(1, 1, 0);
    check_output();

    apply_stimulus("addi_b", 1, 9, 9, 0, 1, 1, 0, 0, 0, 0);
    hz.stage_result = {64'h0, 64'h1};
    expect_out(K_SEL1, 1);
    expect_out(K_D1, 64'h1);
    check_output();

    apply_stimulus("youngest", 1, 10, 9, 0, 1, 1, 1, 0, 0, 0);
    hz.stage_result = {64'h1, 64'h2};
    expect_out(K_SEL1, 1);
    expect_out(K_D1, 64'h2);
    expect_ctrl(1, 1, 0);
    check_output();

    // Producer writing x0
    apply_stimulus("wr_x0", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    check_output();

    // Read x0 (never forwarded) and x10 from stage 2; this instruction writes x11
    apply_stimulus("rd_x0", 1, 11, 0, 10, 1, 1, 1, 0, 0, 0);
    hz.rf_rs1_data  = 64'h0;
    hz.stage_result = {64'h10A, 64'hDEAD};
    expect_out(K_SEL1, 0);
    expect_out(K_D1, 64'h0);
    expect_out(K_SEL2, 2);
    expect_out(K_D2, 64'h10A);
    check_output();

    // Multi-cycle unit busy for 3 cycles; tracker must hold x11 in stage 1
    hz.rf_rs1_data = 64'hAAAA_0001;
    apply_stimulus("mc_1", 1, 12, 11, 0, 1, 1, 0, 0, 0, 0);
    hz.mc_busy      = 1'b1;
    hz.stage_result = {64'h0, 64'h11};
    expect_ctrl(0, 0, 0);
    expect_out(K_SEL1, 1);
    expect_regs(0, 1);
    check_output();

    apply_stimulus("mc_2", 1, 12, 11, 0, 1, 1, 0, 0, 0, 0);
    expect_ctrl(0, 0, 0);
    expect_out(K_SEL1, 1);
    expect_regs(2, 2);
    check_output();

    apply_stimulus("mc_3", 1, 12, 11, 0, 1, 1, 0, 0, 0, 0);
    expect_out(K_SEL1, 1);
    expect_regs(2, 3);
    check_output();

    apply_stimulus("mc_done", 1, 12, 11, 0, 1, 1, 0, 0, 0, 0);
    hz.mc_busy = 1'b0;
    expect_ctrl(1, 1, 0);
    expect_out(K_SEL1, 1);
    expect_out(K_D1, 64'h11);
    expect_regs(2, 4);
    check_output();

    // sd, then fence while memory still busy
    apply_stimulus("sd", 1, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    expect_ctrl(1, 1, 0);
    expect_regs(0, 4);
    check_output();

    apply_stimulus("fence_1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    hz.dm_pending = 1'b1;
    expect_ctrl(0, 1, 1);
    expect_regs(0, 4);
    check_output();

    apply_stimulus("fence_2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_ctrl(0, 1, 1);
    expect_regs(3, 5);
    check_output();

    apply_stimulus("fence_3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_ctrl(0, 1, 1);
    expect_regs(3, 6);
    check_output();

    // Reset mid-drain
    apply_stimulus("rst_drain", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b1;
    expect_ctrl(1, 1, 0);
    expect_regs(3, 7);
    check_output();

    apply_stimulus("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    expect_ctrl(1, 1, 0);
    expect_regs(0, 0);
    check_output();

    // Invalid decode never stalls, even for a fence with memory pending
    apply_stimulus("fence_inv", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_ctrl(1, 1, 0);
    check_output();

    apply_stimulus("fence_dm", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    expect_ctrl(0, 1, 1);
    expect_regs(0, 0);
    check_output();

    apply_stimulus("fence_rel", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    hz.dm_pending = 1'b0;
    expect_ctrl(1, 1, 0);
    expect_regs(3, 1);
    check_output();

    // Invalid decode with a destination must not enter the tracker
    apply_stimulus("inv_rd13", 0, 13, 0, 0, 1, 0, 0, 0, 0, 0);
    expect_ctrl(1, 1, 0);
    expect_regs(0, 1);
    check_output();

    apply_stimulus("rd_x13", 1, 14, 13, 0, 1, 1, 0, 0, 0, 0);
    hz.stage_result = {64'h55, 64'h66};
    expect_out(K_SEL1, 0);
    expect_out(K_D1, 64'hAAAA_0001);
    expect_ctrl(1, 1, 0);
    check_output();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
